// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//
// Decoupling buffer between the fetch stage and the decode stage.
//
// The instruction memory is synchronous: a PC issued in cycle N returns its
// instruction word on fe_inst in cycle N+1. This block remembers the PC of the
// request in flight (fly/fly_pc), pairs it with the returned word, and pushes
// the {pc, inst} pair into a small circular FIFO. The head of the FIFO is
// presented to decode with a valid/ready handshake.
//
// Handshakes:
//   fetch side : a request transfers in any cycle where fe_valid && fe_ready.
//                fe_ready is low whenever the queue plus the in-flight word
//                would fill every slot, so an accepted word always has a free
//                slot to land in. pc_stall = !fe_ready.
//   decode side: the head entry transfers in any cycle where
//                id_valid && id_ready. id_valid depends only on registered
//                state; id_ready has no combinational path to fe_ready.
//
// A flush (if_flush) drops the in-flight word and every queued entry, and
// blocks new requests for that cycle. Reset (rstn, active high, synchronous)
// dominates flush.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rstn      in   1   synchronous reset, active high
//   if_flush  in   1   discard in-flight fetch and queued entries
//   fe_valid  in   1   fetch presents fe_pc this cycle
//   fe_pc     in   32  PC issued this cycle
//   fe_ready  out  1   request accepted this cycle
//   fe_inst   in   32  instruction word for the request accepted last cycle
//   id_valid  out  1   head entry valid
//   id_pc     out  32  head entry PC (0 when empty)
//   id_inst   out  32  head entry instruction (NOP_INST when empty)
//   id_ready  in   1   decode consumes the head entry this cycle
//
// DEPTH must be at least 2; DEPTH >= 3 sustains one instruction per cycle.
// ----------------------------------------------------------------------------
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_flush,
    input  logic        fe_valid,
    input  logic [31:0] fe_pc,
    output logic        fe_ready,
    input  logic [31:0] fe_inst,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          fly;
    logic [31:0]   fly_pc;
    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [CW-1:0] occupancy;
    logic          acc;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    // Slots already committed: queued entries plus the word still in flight.
    // count + fly never exceeds DEPTH, so CW bits are enough.
    assign occupancy = count + {{PW{1'b0}}, fly};

    assign fe_ready = !if_flush && (occupancy < DEPTH_C);
    assign acc      = fe_valid && fe_ready;
    assign push     = fly && !if_flush;
    assign pop      = id_valid && id_ready && !if_flush;

    // Pointers wrap explicitly so that non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_MAX) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // ------------------------------------------------------------------
    // In-flight request tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            fly    <= 1'b0;
            fly_pc <= '0;
        end else begin
            // acc is already forced low during a flush, so a flush leaves
            // nothing in flight.
            fly <= acc;
            if (acc) begin
                fly_pc <= fe_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (data only; validity is tracked by count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn && push) begin
            mem[wr_ptr] <= {fly_pc, fe_inst};
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (if_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decode-side outputs; defined constants when empty so stale storage
    // (or never-written storage after reset) is never visible.
    // ------------------------------------------------------------------
    assign head     = mem[rd_ptr];
    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? head[63:32] : 32'h0;
    assign id_inst  = id_valid ? head[31:0]  : NOP_INST;

endmodule

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
//
// Directed bench for if_id_queue (DEPTH=4). The instruction memory is a small
// ROM (inst_of) whose output for the PC issued in one cycle is driven on
// fe_inst in the next. A reference model (m_fly, m_fly_pc, m_count, exp_q)
// tracks what the queue must hold; every cycle the DUT outputs are compared
// against it, and the scenarios add hand-computed constant checks.
// ----------------------------------------------------------------------------
module tb_if_id_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rstn;
    logic        if_flush;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic        fe_ready;
    logic [31:0] fe_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .if_flush (if_flush),
        .fe_valid (fe_valid),
        .fe_pc    (fe_pc),
        .fe_ready (fe_ready),
        .fe_inst  (fe_inst),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic        m_fly;
    logic [31:0] m_fly_pc;
    int          m_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction ROM contents.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        case (pc)
            32'h100: inst_of = 32'h00500093;
            32'h200: inst_of = 32'h00a00113;
            default: inst_of = {pc[19:0], 12'h093};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks. Each call runs from 1 time unit after one rising edge
    // to 1 time unit after the next; inputs are driven and outputs
    // sampled there, away from the edge.
    // ------------------------------------------------------------------
    task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, output logic accepted);
        logic        m_ready;
        logic        push;
        logic        pop;
        logic [31:0] prev_pc;
        fe_valid = v;
        fe_pc    = pc;
        id_ready = rdy;
        if_flush = fl;
        #1;
        m_ready = !fl && (m_count + int'(m_fly) < DEPTH);
        check("fe_ready", 64'(fe_ready), 64'(m_ready));
        check("id_valid", 64'(id_valid), 64'(m_count != 0));
        if (m_count != 0 && exp_q.size() != 0) begin
            check("id_pc", 64'(id_pc), 64'(exp_q[0][63:32]));
            check("id_inst", 64'(id_inst), 64'(exp_q[0][31:0]));
        end else begin
            check("id_pc_empty", 64'(id_pc), 64'h0);
            check("id_inst_empty", 64'(id_inst), 64'(NOP));
        end
        accepted = v && m_ready;
        push     = m_fly && !fl;
        pop      = (m_count != 0) && rdy && !fl;
        if (fl) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({m_fly_pc, inst_of(m_fly_pc)});
            m_count = m_count + int'(push) - int'(pop);
        end
        m_fly = accepted;
        if (accepted) m_fly_pc = pc;
        prev_pc = pc;
        @(posedge clk);
        #1;
        fe_inst = inst_of(prev_pc);
    endtask

    task automatic do_reset(input logic fl);
        rstn     = 1'b1;
        if_flush = fl;
        fe_valid = 1'b1;
        fe_pc    = 32'h0;
        id_ready = 1'b0;
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        if_flush = 1'b0;
        fe_valid = 1'b0;
        fe_inst  = 32'h0;
        m_fly    = 1'b0;
        m_fly_pc = 32'h0;
        m_count  = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        #1;
        check("rst_id_valid", 64'(id_valid), 64'h0);
        check("rst_id_pc", 64'(id_pc), 64'h0);
        check("rst_id_inst", 64'(id_inst), 64'h00000013);
        check("rst_fe_ready", 64'(fe_ready), 64'h1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        a;
        logic [31:0] pc;

        rstn = 1'b1; if_flush = 1'b0; fe_valid = 1'b0; fe_pc = '0;
        fe_inst = '0; id_ready = 1'b0;
        m_fly = 1'b0; m_fly_pc = '0; m_count = 0;

        // Reset then idle.
        do_reset(1'b0);
        check_reset_outputs();
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, a);

        // Single fetch, held by decode, then consumed.
        cyc(1'b1, 32'h100, 1'b0, 1'b0, a);
        check("single_acc", 64'(a), 64'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
        #1;
        check("single_valid", 64'(id_valid), 64'h1);
        check("single_pc", 64'(id_pc), 64'h100);
        check("single_inst", 64'(id_inst), 64'h00500093);
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
        check("single_hold_pc", 64'(id_pc), 64'h100);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a);
        check("single_popped", 64'(id_valid), 64'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a);   // pop request while empty

        // Streaming with decode always ready: one per cycle from cycle 3.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                check("stream_valid", 64'(id_valid), 64'h1);
                check("stream_pc", 64'(id_pc), 64'(32'(4 * (i - 2))));
            end
            cyc(1'b1, 32'(4 * i), 1'b1, 1'b0, a);
            check("stream_acc", 64'(a), 64'h1);
        end
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Backpressure: fill, observe the stall, then drain in order.
        do_reset(1'b0);
        pc = 32'h0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, pc, 1'b0, 1'b0, a);
            if (a) pc = pc + 32'h4;
        end
        check("bp_accepted", 64'(pc), 64'h10);
        #1;
        check("bp_stall", 64'(fe_ready), 64'h0);
        for (int k = 0; k < 4; k++) begin
            check("drain_pc", 64'(id_pc), 64'(32'(4 * k)));
            cyc(1'b0, 32'h0, 1'b1, 1'b0, a);
        end
        check("drain_empty", 64'(id_valid), 64'h0);

        // Flush with two queued and one in flight, then redirect.
        do_reset(1'b0);
        cyc(1'b1, 32'h300, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h304, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h308, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h30c, 1'b1, 1'b1, a);
        check("flush_no_acc", 64'(a), 64'h0);
        #1;
        check("flush_empty", 64'(id_valid), 64'h0);
        cyc(1'b1, 32'h200, 1'b0, 1'b0, a);
        check("redirect_acc", 64'(a), 64'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
        #1;
        check("redirect_pc", 64'(id_pc), 64'h200);
        check("redirect_inst", 64'(id_inst), 64'h00a00113);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Push and pop together at count=1 with a non-consecutive PC order.
        do_reset(1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h80, 1'b0, 1'b0, a);
        cyc(1'b1, 32'hc0, 1'b1, 1'b0, a);
        check("pp_pc", 64'(id_pc), 64'h80);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a);
        check("pp_pc2", 64'(id_pc), 64'hc0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Reset while full, then reset together with a flush.
        pc = 32'h500;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, pc, 1'b0, 1'b0, a);
            if (a) pc = pc + 32'h4;
        end
        do_reset(1'b0);
        check_reset_outputs();
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h600, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h604, 1'b0, 1'b0, a);
        do_reset(1'b1);
        check_reset_outputs();
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage and the decode stage.
- Tracks the one-cycle latency of the synchronous instruction memory: the PC is issued in cycle N and the instruction word returns in cycle N+1.
- Pairs each returned instruction with its PC and queues the pair in a small FIFO.
- Presents the head entry to decode with a valid/ready handshake.
- Generates the fetch-side stall, which drives pc_stall, and discards all in-flight and queued work on a pipeline flush.

Parameters:
- DEPTH, 4, number of {pc, inst} queue entries. Minimum is 2; at least 3 is required for one-per-cycle throughput.
- NOP_INST, 32'h00000013, value driven on id_inst when the queue is empty.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous, active-high reset (asserted = 1); the name is kept for port-list consistency across stages.
- if_flush  input  1  discard in-flight fetch and all queued entries.
- fe_valid  input  1  fetch stage presents fe_pc to instruction memory this cycle.
- fe_pc  input  32  PC issued this cycle.
- fe_ready  output  1  request accepted this cycle; pc_stall = !fe_ready.
- fe_inst  input  32  instruction memory data; valid the cycle after an accepted request.
- id_valid  output  1  head entry valid.
- id_pc  output  32  head entry PC.
- id_inst  output  32  head entry instruction.
- id_ready  input  1  decode consumes head this cycle.

Behaviour:
- State registers:
  - fly (1 bit) and fly_pc (32 bits).
  - Storage of DEPTH x 64 bits.
  - wr_ptr and rd_ptr, each clog2(DEPTH) bits.
  - count, clog2(DEPTH)+1 bits.
- Reset (rstn=1 at edge):
  - fly, fly_pc, pointers and count are set to 0.
  - Outputs after reset: id_valid=0, id_pc=0, id_inst=NOP_INST, fe_ready=1 (when if_flush=0).
- Accept:
  - fe_ready = !if_flush && (count + fly < DEPTH).
  - fe_ready has no combinational dependence on id_ready; this is conservative and never overflows.
  - acc = fe_valid && fe_ready.
  - At the edge: fly <= acc and, when acc=1, fly_pc <= fe_pc.
- Push:
  - push = fly && !if_flush.
  - On push: storage[wr_ptr] <= {fly_pc, fe_inst} and wr_ptr increments.
- Pop:
  - pop = id_valid && id_ready && !if_flush.
  - On pop, rd_ptr increments.
- Count:
  - count <= count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
- Pointers wrap to 0 after DEPTH-1, including for non-power-of-2 DEPTH.
- Outputs:
  - id_valid = (count != 0).
  - id_pc and id_inst come from storage[rd_ptr].
  - When count == 0, id_pc=0 and id_inst=NOP_INST.
- Latency: request accepted in cycle N gives id_valid in cycle N+2 (empty queue case); there is no bypass path.
- Throughput: with DEPTH>=3 and id_ready held at 1, one instruction is delivered per cycle in steady state (count=1, fly=1).
- Full: when count + fly == DEPTH, fe_ready=0. The in-flight word still lands in a guaranteed free slot.
- Empty with pop request: id_ready=1 while count=0 has no effect.
- Flush:
  - if_flush=1 at an edge gives fly=0, count=0, wr_ptr=rd_ptr=0.
  - Flush dominates push, pop and accept in the same cycle; fe_inst returned that cycle is dropped.
  - fe_ready=0 throughout the flush cycle.
  - The cycle after flush, fe_ready=1 and the redirected PC may be accepted.
- Reset dominates flush.
- Reset is allowed mid-operation; all state is cleared regardless of fly or count.
- No X propagation: outputs are defined whenever count==0.

Test Plan:
- Reset then idle -> id_valid=0, id_inst=32'h00000013, id_pc=0, fe_ready=1.
- Single fetch, fe_pc=0x100 accepted in cycle 1, fe_inst=0x00500093 in cycle 2, id_ready=0 -> cycle 3: id_valid=1, id_pc=0x100, id_inst=0x00500093; entry holds until id_ready=1.
- Streaming PCs 0x0,0x4,0x8,... with id_ready=1, DEPTH=4 -> from cycle 3 one instruction per cycle in PC order; fe_ready never drops.
- Backpressure: id_ready=0 while streaming -> fe_ready falls to 0 when count+fly==4; exactly 4 entries held; then release id_ready -> entries drain in order 0x0,0x4,0x8,0xC with no loss or duplication.
- Flush with 2 queued and 1 in flight, if_flush=1 for one cycle -> next cycle id_valid=0; the dropped fe_inst never appears; redirect PC 0x200 accepted next cycle reaches id_pc in 2 cycles.
- Simultaneous push and pop at count=1, and rstn=1 asserted while full -> count stays 1 with correct ordering; after reset, all outputs return to reset values.
